branch_pred_tracker: RTL

// - In-order queue of in-flight conditional-branch predictions, between fetch/predict and the tournament chooser.
// - At fetch it records the PC, the local-predictor bit, the global-predictor bit and the chooser select.
// - At branch resolution it pops the oldest entry and produces the registered chooser-update bundle:

---
 rtl/branch_pred_tracker_pkg.sv | 26 ++
 rtl/branch_pred_tracker_bpq_fifo.sv | 52 +++++
 rtl/branch_pred_tracker.sv | 92 +++++++++
 3 files changed

// File: rtl/branch_pred_tracker_pkg.sv
// Shared types for the branch prediction tracker: the LC-3b word, the
// queue entry recorded at fetch, the default depth and the predictor muxes.
package branch_pred_tracker_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    logic     local_pred;
    logic     global_pred;
    logic     chooser;
  } lc3b_bpq_entry;

  localparam int BPQ_DEPTH = 4;

  // Prediction that the chooser actually used for this branch
  function automatic logic pick_chosen(input lc3b_bpq_entry e);
    return e.chooser ? e.global_pred : e.local_pred;
  endfunction

  // Prediction of the predictor the chooser did not select
  function automatic logic pick_unchosen(input lc3b_bpq_entry e);
    return e.chooser ? e.local_pred : e.global_pred;
  endfunction

endpackage

// File: rtl/branch_pred_tracker_bpq_fifo.sv
// In-order storage for in-flight branch predictions. Pointers carry an
// extra wrap bit so full and empty are told apart without a counter.
module bpq_fifo
  import branch_pred_tracker_pkg::*;
#(
  parameter int DEPTH = BPQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  lc3b_bpq_entry push_data,
  output lc3b_bpq_entry pop_data,
  output logic          full,
  output logic          empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  lc3b_bpq_entry    mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (head == tail);
  assign full     = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full queue is legal then
  assign push_ok  = push && !clear && (!full || pop_ok);
  assign pop_data = mem[head[IDX_W-1:0]];

  // Pointer update; clear flushes all wrong-path entries at once
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_ONE;
      if (pop_ok)  head <= head + PTR_ONE;
    end
  end

  // Entry storage, written at the tail index when a push is accepted
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_pred_tracker.sv
// Tracks in-flight conditional-branch predictions between fetch and the
// tournament chooser, producing the registered chooser-update bundle when
// the oldest branch resolves, plus mispredict counting and error flagging.
module branch_pred_tracker
  import branch_pred_tracker_pkg::*;
#(
  parameter int DEPTH = BPQ_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc,
  input  logic [15:0] alloc_pc,
  input  logic        local_pred,
  input  logic        global_pred,
  input  logic        chooser,
  input  logic        resolve,
  input  logic        resolve_taken,
  output logic        full,
  output logic        empty,
  output logic        write,
  output logic [15:0] write_pc,
  output logic        taken,
  output logic        control_flush,
  output logic        unchosen_pred,
  output logic [15:0] mispredict_count,
  output logic        resolve_err
);

  lc3b_bpq_entry alloc_entry;
  lc3b_bpq_entry head_entry;
  logic          pop_valid;
  logic          mispredict;
  logic          push;

  assign alloc_entry = '{pc: alloc_pc, local_pred: local_pred,
                         global_pred: global_pred, chooser: chooser};

  assign pop_valid  = resolve && !empty;
  assign mispredict = pop_valid && (resolve_taken != pick_chosen(head_entry));
  // Anything fetched alongside a mispredicting branch is on the wrong path
  assign push       = alloc && !mispredict;

  bpq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop_valid),
    .clear    (mispredict),
    .push_data(alloc_entry),
    .pop_data (head_entry),
    .full     (full),
    .empty    (empty)
  );

  // One-cycle chooser-update pulse; all fields return to zero when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      write         <= 1'b0;
      write_pc      <= '0;
      taken         <= 1'b0;
      control_flush <= 1'b0;
      unchosen_pred <= 1'b0;
    end else begin
      write         <= pop_valid;
      write_pc      <= pop_valid ? head_entry.pc : '0;
      taken         <= pop_valid && resolve_taken;
      control_flush <= mispredict;
      unchosen_pred <= pop_valid && pick_unchosen(head_entry);
    end
  end

  // Saturating mispredict counter, stepped alongside control_flush
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (mispredict && (mispredict_count != 16'hFFFF)) begin
      mispredict_count <= mispredict_count + 16'd1;
    end
  end

  // Sticky flag for a resolve arriving with nothing in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      resolve_err <= 1'b0;
    end else if (resolve && empty) begin
      resolve_err <= 1'b1;
    end
  end

endmodule
